// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared sizing and types for the two-wide register scoreboard.
package dual_issue_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = $clog2(NUM_REGS) + 1;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
  } slot_req_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] rd;
  } wb_req_t;
endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Issue/writeback/status bundle between the decoders, writeback ports and scoreboard.
interface dual_issue_scoreboard_if;
  import dual_issue_scoreboard_pkg::*;
  logic                flush;
  logic                s0_valid, s1_valid;
  logic [ADDR_W-1:0]   s0_rs1, s0_rs2, s0_rd;
  logic [ADDR_W-1:0]   s1_rs1, s1_rs2, s1_rd;
  logic                wb0_en, wb1_en;
  logic [ADDR_W-1:0]   wb0_rd, wb1_rd;
  logic                issue0, issue1;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    busy_cnt;
  logic                wb_err;

  modport master (
    output flush, s0_valid, s0_rs1, s0_rs2, s0_rd, s1_valid, s1_rs1, s1_rs2, s1_rd,
           wb0_en, wb0_rd, wb1_en, wb1_rd,
    input  issue0, issue1, busy_vec, busy_cnt, wb_err
  );
  modport slave (
    input  flush, s0_valid, s0_rs1, s0_rs2, s0_rd, s1_valid, s1_rs1, s1_rs2, s1_rd,
           wb0_en, wb0_rd, wb1_en, wb1_rd,
    output issue0, issue1, busy_vec, busy_cnt, wb_err
  );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// Busy-bit scoreboard for the in-order two-wide pipe: RAW/WAW issue check against
// registered busy bits plus intra-pair dependence check; set on issue, clear on writeback.
module dual_issue_scoreboard
  import dual_issue_scoreboard_pkg::*;
(
  input logic clk,
  input logic rst_n,
  dual_issue_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0] busy_vec_q, busy_vec_d, set_vec, clr_vec;
  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;
  logic                wb_err_q, wb_err_d;
  slot_req_t           s0, s1;
  wb_req_t             wb0, wb1;
  logic                issue0, issue1, pair_dep;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  function automatic logic hz(input logic [ADDR_W-1:0] a, input logic [NUM_REGS-1:0] bv);
    return (a != REG_ZERO) && bv[a];
  endfunction

  assign s0  = '{valid: sb.s0_valid, rs1: sb.s0_rs1, rs2: sb.s0_rs2, rd: sb.s0_rd};
  assign s1  = '{valid: sb.s1_valid, rs1: sb.s1_rs1, rs2: sb.s1_rs2, rd: sb.s1_rd};
  assign wb0 = '{en: sb.wb0_en, rd: sb.wb0_rd};
  assign wb1 = '{en: sb.wb1_en, rd: sb.wb1_rd};

  // No writeback bypass: hazards see only the registered busy bits.
  always_comb begin
    pair_dep = (s0.rd != REG_ZERO) &&
               (s1.rs1 == s0.rd || s1.rs2 == s0.rd || s1.rd == s0.rd);
    issue0   = s0.valid && !sb.flush && !hz(s0.rs1, busy_vec_q) &&
               !hz(s0.rs2, busy_vec_q) && !hz(s0.rd, busy_vec_q);
    issue1   = issue0 && s1.valid && !hz(s1.rs1, busy_vec_q) &&
               !hz(s1.rs2, busy_vec_q) && !hz(s1.rd, busy_vec_q) && !pair_dep;
    set_vec  = (issue0 ? onehot(s0.rd) : '0) | (issue1 ? onehot(s1.rd) : '0);
    clr_vec  = (wb0.en ? onehot(wb0.rd) : '0) | (wb1.en ? onehot(wb1.rd) : '0);
  end

  assign busy_vec_d[0] = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_busy
    // Set wins over a same-cycle clear.
    assign busy_vec_d[i] = !sb.flush && (set_vec[i] || (busy_vec_q[i] && !clr_vec[i]));
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 1; i < NUM_REGS; i++)
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_vec_d[i]);
    wb_err_d = wb_err_q ||
               (!sb.flush && wb0.en && wb0.rd != REG_ZERO && !busy_vec_q[wb0.rd]) ||
               (!sb.flush && wb1.en && wb1.rd != REG_ZERO && !busy_vec_q[wb1.rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec_q <= '0;
      busy_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_vec_q <= busy_vec_d;
      busy_cnt_q <= busy_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign sb.issue0   = issue0;
  assign sb.issue1   = issue1;
  assign sb.busy_vec = busy_vec_q;
  assign sb.busy_cnt = busy_cnt_q;
  assign sb.wb_err   = wb_err_q;
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed vector bench for dual_issue_scoreboard.
module tb_dual_issue_scoreboard;
  import dual_issue_scoreboard_pkg::*;

  typedef struct {
    logic        flush;
    logic        s0v;
    logic [4:0]  s0r1, s0r2, s0rd;
    logic        s1v;
    logic [4:0]  s1r1, s1r2, s1rd;
    logic        w0e;
    logic [4:0]  w0rd;
    logic        w1e;
    logic [4:0]  w1rd;
    logic        ei0, ei1;
    logic [31:0] ebusy;
    logic [5:0]  ecnt;
    logic        eerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dual_issue_scoreboard_if sb();
  dual_issue_scoreboard dut (.clk(clk), .rst_n(rst_n), .sb(sb));

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic fl, input logic a_v, input int a1, input int a2, input int ad,
    input logic b_v, input int b1, input int b2, input int bd,
    input logic w0, input int w0r, input logic w1, input int w1r,
    input logic i0, input logic i1, input logic [31:0] bz, input int cnt, input logic er);
    vec_t v;
    v.flush = fl; v.s0v = a_v; v.s0r1 = 5'(a1); v.s0r2 = 5'(a2); v.s0rd = 5'(ad);
    v.s1v = b_v; v.s1r1 = 5'(b1); v.s1r2 = 5'(b2); v.s1rd = 5'(bd);
    v.w0e = w0; v.w0rd = 5'(w0r); v.w1e = w1; v.w1rd = 5'(w1r);
    v.ei0 = i0; v.ei1 = i1; v.ebusy = bz; v.ecnt = 6'(cnt); v.eerr = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb.flush = v.flush;
    sb.s0_valid = v.s0v; sb.s0_rs1 = v.s0r1; sb.s0_rs2 = v.s0r2; sb.s0_rd = v.s0rd;
    sb.s1_valid = v.s1v; sb.s1_rs1 = v.s1r1; sb.s1_rs2 = v.s1r2; sb.s1_rd = v.s1rd;
    sb.wb0_en = v.w0e; sb.wb0_rd = v.w0rd; sb.wb1_en = v.w1e; sb.wb1_rd = v.w1rd;
  endtask

  task automatic idle();
    drive(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0,0));
  endtask

  // Drive at negedge, check issue before the edge, check state just after it.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".issue0"}, 32'(sb.issue0), 32'(v.ei0));
    check({tag, ".issue1"}, 32'(sb.issue1), 32'(v.ei1));
    @(posedge clk);
    #1;
    check({tag, ".busy_vec"}, sb.busy_vec, v.ebusy);
    check({tag, ".busy_cnt"}, 32'(sb.busy_cnt), 32'(v.ecnt));
    check({tag, ".wb_err"}, 32'(sb.wb_err), 32'(v.eerr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("rst.busy_vec", sb.busy_vec, 32'h0);
    check("rst.busy_cnt", 32'(sb.busy_cnt), 32'h0);
    check("rst.wb_err", 32'(sb.wb_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[19];

  initial begin
    //         fl s0v r1 r2 rd  s1v r1 r2 rd  w0e rd w1e rd  i0 i1 busy          cnt err
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 32'h0,        0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 5,  1, 5, 0, 0,  0, 0,  0, 0,  1, 0, 32'h20,       1, 0);
    tbl[2]  = mk(0, 1, 0, 1, 3,  1, 1, 0, 4,  1, 5,  0, 0,  1, 1, 32'h18,       2, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 3,  1, 4,  0, 0, 32'h0,        0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 0,  1, 9,  0, 0,  1, 1, 32'h0,        0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 32'h0,        0, 1);
    tbl[6]  = mk(0, 1, 0, 0, 7,  0, 0, 0, 0,  0, 0,  0, 0,  1, 0, 32'h80,       1, 1);
    tbl[7]  = mk(0, 1, 0, 7, 8,  1, 0, 0,10,  0, 0,  1, 7,  0, 0, 32'h0,        0, 1);
    tbl[8]  = mk(0, 1, 0, 7, 8,  1, 0, 0,10,  0, 0,  0, 0,  1, 1, 32'h500,      2, 1);
    tbl[9]  = mk(1, 1, 0, 0, 1,  1, 0, 0, 2,  1,12,  0, 0,  0, 0, 32'h0,        0, 1);
    tbl[10] = mk(0, 1, 0, 0, 1,  1, 0, 0, 1,  0, 0,  0, 0,  1, 0, 32'h2,        1, 1);
    tbl[11] = mk(0, 1, 0, 0, 2,  1, 0, 0, 1,  0, 0,  0, 0,  1, 0, 32'h6,        2, 1);
    tbl[12] = mk(0, 1, 0, 0, 2,  1, 0, 0,20,  0, 0,  0, 0,  0, 0, 32'h6,        2, 1);
    tbl[13] = mk(1, 1, 0, 0, 3,  1, 0, 0, 4,  0, 0,  0, 0,  0, 0, 32'h0,        0, 1);
    tbl[14] = mk(0, 1, 0, 0,15,  1, 0,15, 0,  0, 0,  0, 0,  1, 0, 32'h8000,     1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0,  1, 0, 0,16,  0, 0,  0, 0,  0, 0, 32'h8000,     1, 1);
    tbl[16] = mk(0, 1, 0, 0,17,  1, 0,15,18,  0, 0,  0, 0,  1, 0, 32'h28000,    2, 1);
    tbl[17] = mk(0, 1, 0, 0,31,  1, 0, 0,30,  0, 0,  0, 0,  1, 1, 32'hC002_8000, 4, 1);
    tbl[18] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 32'h0,        0, 1);

    idle();
    sb.s0_valid = 1'b1;
    #2;
    check("in_rst.busy_vec", sb.busy_vec, 32'h0);
    check("in_rst.busy_cnt", 32'(sb.busy_cnt), 32'h0);
    check("in_rst.wb_err", 32'(sb.wb_err), 32'h0);
    check("in_rst.issue0", 32'(sb.issue0), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 4..7, double writeback to one register, then async reset mid-cycle.
    run_vec("seqA.0", mk(0, 1,0,0,4, 1,0,0,5, 0,0, 0,0, 1,1, 32'h30, 2, 0));
    run_vec("seqA.1", mk(0, 1,0,0,6, 1,0,0,7, 0,0, 0,0, 1,1, 32'hF0, 4, 0));
    run_vec("seqA.2", mk(0, 0,0,0,0, 0,0,0,0, 1,4, 1,4, 0,0, 32'hE0, 3, 0));
    run_vec("seqA.3", mk(0, 1,0,0,4, 0,0,0,0, 0,0, 0,0, 1,0, 32'hF0, 4, 0));
    do_reset();

    // Issue to a non-busy register while it is written back: set wins, error raised.
    run_vec("seqB.0", mk(0, 1,0,0,3, 0,0,0,0, 1,3, 0,0, 1,0, 32'h8, 1, 1));
    do_reset();

    for (int i = 0; i < 19; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
